// File: rtl/apb_can_txq.sv
// APB front end for the CAN transmitter: staging registers, a DEPTH-entry frame
// queue and a sequencer that launches queued frames whenever the transmitter is idle.
module apb_can_txq #(
   parameter int DEPTH        = 4,
   parameter int BUSY_TIMEOUT = 16,
   parameter int ADDR_W       = 8
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              startXmit,
   output logic [7:0]        quantaDiv,
   output logic [5:0]        propQuanta,
   output logic [5:0]        seg1Quanta,
   output logic [3:0]        datalen,
   output logic              format,
   output logic [1:0]        frameType,
   output logic [28:0]       id,
   output logic [63:0]       xmitdata,
   input  logic              busy,
   output logic              irq
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

   localparam logic [ADDR_W-1:0] A_DHI = ADDR_W'('h00);
   localparam logic [ADDR_W-1:0] A_DLO = ADDR_W'('h04);
   localparam logic [ADDR_W-1:0] A_CMD = ADDR_W'('h08);
   localparam logic [ADDR_W-1:0] A_ID  = ADDR_W'('h0C);
   localparam logic [ADDR_W-1:0] A_CTL = ADDR_W'('h10);
   localparam logic [ADDR_W-1:0] A_IEN = ADDR_W'('h14);
   localparam logic [ADDR_W-1:0] A_IST = ADDR_W'('h18);

   typedef struct packed {
      logic [7:0]  qdiv;
      logic [5:0]  prop;
      logic [5:0]  seg1;
      logic [3:0]  dlen;
      logic        fmt;
      logic [1:0]  ftype;
      logic [28:0] fid;
      logic [63:0] data;
   } frame_t;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   logic [31:0]   data_hi, data_lo, cmd_r, id_r;
   logic [2:0]    irq_en, irq_stat, w1c;
   frame_t        mem [DEPTH];
   frame_t        staged, head;
   logic [PW-1:0] rd_ptr, wr_ptr, count, flush_base, wr_base;
   state_t        st;
   logic [TW-1:0] timer;

   logic          access, wr_acc, rd_acc, mapped;
   logic          push_req, flush, push_ok, push_rej;
   logic          full, empty, timeout, pop, done_set;
   logic [31:0]   status, rdata;

   assign access = PSEL & PENABLE;
   assign wr_acc = access & PWRITE;
   assign rd_acc = access & ~PWRITE;

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == PW'(DEPTH));
   assign empty = (count == '0);

   assign timeout  = (st == WAIT_BUSY) && !busy && (timer == TW'(BUSY_TIMEOUT - 1));
   assign done_set = (st == WAIT_DONE) && !busy;
   assign pop      = timeout | done_set;

   assign push_req = wr_acc && (PADDR == A_CTL) && PWDATA[0];
   assign flush    = wr_acc && (PADDR == A_CTL) && PWDATA[1];
   // A flush or a same-cycle pop always frees a slot, so only a plain push to a full queue is refused
   assign push_ok  = push_req && (flush || !full || pop);
   assign push_rej = push_req && !push_ok;

   // The in-flight head survives a flush unless the sequencer is idle
   assign flush_base = (st == IDLE) ? rd_ptr : rd_ptr + PW'(1);
   assign wr_base    = flush ? flush_base : wr_ptr;

   assign w1c = (wr_acc && (PADDR == A_IST)) ? PWDATA[2:0] : 3'b000;

   assign staged = {cmd_r[31:24], cmd_r[23:18], cmd_r[17:12], cmd_r[11:8], cmd_r[7],
                    cmd_r[6:5], id_r[31:3], data_hi, data_lo};

   assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign quantaDiv  = head.qdiv;
   assign propQuanta = head.prop;
   assign seg1Quanta = head.seg1;
   assign datalen    = head.dlen;
   assign format     = head.fmt;
   assign frameType  = head.ftype;
   assign id         = head.fid;
   assign xmitdata   = head.data;

   always_comb begin
      status         = '0;
      status[8 +: PW] = count;
      status[4]      = irq_stat[2];
      status[3]      = irq_stat[1];
      status[2]      = full;
      status[1]      = empty;
      status[0]      = busy;
   end

   always_comb begin
      rdata  = '0;
      mapped = 1'b1;
      case (PADDR)
         A_DHI:   rdata = data_hi;
         A_DLO:   rdata = data_lo;
         A_CMD:   rdata = cmd_r;
         A_ID:    rdata = id_r;
         A_CTL:   rdata = status;
         A_IEN:   rdata = {29'b0, irq_en};
         A_IST:   rdata = {29'b0, irq_stat};
         default: mapped = 1'b0;
      endcase
   end

   assign PREADY  = 1'b1;
   assign PRDATA  = (rd_acc && !PRESET) ? rdata : '0;
   assign PSLVERR = access && !PRESET && (!mapped || push_rej);
   assign irq     = |(irq_stat & irq_en);

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         data_hi  <= '0;
         data_lo  <= '0;
         cmd_r    <= '0;
         id_r     <= '0;
         irq_en   <= '0;
         irq_stat <= '0;
         wr_ptr   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_acc) begin
            case (PADDR)
               A_DHI:   data_hi <= PWDATA;
               A_DLO:   data_lo <= PWDATA;
               A_CMD:   cmd_r   <= {PWDATA[31:5], 5'b0};
               A_ID:    id_r    <= {PWDATA[31:3], 3'b0};
               A_IEN:   irq_en  <= PWDATA[2:0];
               default: ;
            endcase
         end
         // set events override a simultaneous W1C
         irq_stat <= (irq_stat & ~w1c) | {timeout, push_rej, done_set};
         if (push_ok) mem[wr_base[AW-1:0]] <= staged;
         wr_ptr <= wr_base + PW'(push_ok);
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         st        <= IDLE;
         timer     <= '0;
         startXmit <= 1'b0;
         rd_ptr    <= '0;
      end else begin
         startXmit <= 1'b0;
         case (st)
            IDLE: if (!empty && !busy) st <= LAUNCH;
            LAUNCH: begin
               startXmit <= 1'b1;
               timer     <= '0;
               st        <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (busy) st <= WAIT_DONE;
               else if (timeout) begin
                  rd_ptr <= rd_ptr + PW'(1);
                  st     <= IDLE;
               end else timer <= timer + TW'(1);
            end
            WAIT_DONE: if (!busy) begin
               rd_ptr <= rd_ptr + PW'(1);
               st     <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_can_txq.sv
// Randomized bench for apb_can_txq: a frame-queue reference model plus a transmitter
// emulator that checks every launched frame against the model queue.
module tb_apb_can_txq;
   localparam int DEPTH = 4, BUSY_TIMEOUT = 16, ADDR_W = 8;

   logic        PCLK = 1'b0, PRESET = 1'b1, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [7:0]  PADDR = '0;
   logic [31:0] PWDATA = '0, PRDATA;
   logic        PREADY, PSLVERR, startXmit, format, busy, irq;
   logic [7:0]  quantaDiv;
   logic [5:0]  propQuanta, seg1Quanta;
   logic [3:0]  datalen;
   logic [1:0]  frameType;
   logic [28:0] id;
   logic [63:0] xmitdata;
   logic        hold_busy = 1'b0, xc_busy = 1'b0;

   assign busy = hold_busy | xc_busy;
   always #5 PCLK = ~PCLK;

   apb_can_txq #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .startXmit(startXmit), .quantaDiv(quantaDiv), .propQuanta(propQuanta),
      .seg1Quanta(seg1Quanta), .datalen(datalen), .format(format), .frameType(frameType),
      .id(id), .xmitdata(xmitdata), .busy(busy), .irq(irq));

   int n_cmp = 0, n_bad = 0;
   logic [119:0] model_q [$];
   logic [119:0] exp_f;
   logic        in_flight = 1'b0, done_exp = 1'b0, ovf_exp = 1'b0, err_exp = 1'b0;
   logic [2:0]  ien_exp = '0;
   int          launches = 0, xmode = 0, xd = 2, xl = 6;
   logic [31:0] st_hi = '0, st_lo = '0, st_cmd = '0, st_id = '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Frame fields taken straight from the register-map bit positions.
   function automatic logic [119:0] pack_frame(input logic [31:0] hi, lo, cmd, idv);
      logic [7:0]  q;  logic [5:0] p, s; logic [3:0] dl; logic f; logic [1:0] ft; logic [28:0] ident;
      q  = 8'((cmd >> 24) & 32'hFF);
      p  = 6'((cmd >> 18) & 32'h3F);
      s  = 6'((cmd >> 12) & 32'h3F);
      dl = 4'((cmd >> 8) & 32'hF);
      f  = 1'((cmd >> 7) & 32'h1);
      ft = 2'((cmd >> 5) & 32'h3);
      ident = 29'(idv >> 3);
      return {q, p, s, dl, f, ft, ident, hi, lo};
   endfunction

   function automatic logic [31:0] status_exp();
      int c;
      c = model_q.size() + int'(in_flight);
      return (32'(c) << 8) | (32'(err_exp) << 4) | (32'(ovf_exp) << 3) |
             (32'(c == DEPTH) << 2) | (32'(c == 0) << 1) | 32'(busy);
   endfunction

   task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] r, output logic e);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #1; r = PRDATA; e = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] r; logic e;
      apb(1'b1, a, d, r, e);
      chk("wr_pslverr", 128'(e), 128'(0));
   endtask

   task automatic reg_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] r; logic e;
      apb(1'b0, a, 32'h0, r, e);
      chk(tag, 128'(r), 128'(exp));
      chk({tag, "_pslverr"}, 128'(e), 128'(0));
   endtask

   task automatic chk_status(input string tag);
      logic [31:0] r; logic e;
      apb(1'b0, 8'h10, 32'h0, r, e);
      chk(tag, 128'(r), 128'(status_exp()));
   endtask

   task automatic stage(input logic [31:0] hi, lo, cmd, idv);
      reg_wr(8'h00, hi); reg_wr(8'h04, lo); reg_wr(8'h08, cmd); reg_wr(8'h0C, idv);
      st_hi = hi; st_lo = lo; st_cmd = cmd; st_id = idv;
   endtask

   task automatic push();
      logic [31:0] r; logic e, rej;
      rej = (model_q.size() + int'(in_flight)) >= DEPTH;
      apb(1'b1, 8'h10, 32'h1, r, e);
      chk("push_pslverr", 128'(e), 128'(rej));
      if (rej) ovf_exp = 1'b1;
      else model_q.push_back(pack_frame(st_hi, st_lo, st_cmd, st_id));
   endtask

   task automatic push_rand();
      stage($urandom, $urandom, $urandom, $urandom);
      push();
   endtask

   task automatic w1c(input logic [2:0] v);
      reg_wr(8'h18, {29'b0, v});
      if (v[0]) done_exp = 1'b0;
      if (v[1]) ovf_exp = 1'b0;
      if (v[2]) err_exp = 1'b0;
   endtask

   task automatic chk_irq(input string tag);
      reg_rd({tag, "_stat"}, 8'h18, {29'b0, err_exp, ovf_exp, done_exp});
      chk({tag, "_irq"}, 128'(irq), 128'(|({err_exp, ovf_exp, done_exp} & ien_exp)));
   endtask

   task automatic wait_drain(input int max);
      int k = 0;
      while ((model_q.size() != 0 || in_flight) && k < max) begin
         @(posedge PCLK); k++;
      end
      #1;
      chk("drain", 128'(model_q.size() == 0 && !in_flight), 128'(1));
   endtask

   // Transmitter emulator: mode 0 pulses busy, mode 1 never raises busy, mode 2 leaves busy to the main flow.
   initial begin
      forever begin
         @(negedge PCLK);
         if (startXmit === 1'b1) begin
            launches++;
            chk("launch_nonempty", 128'(model_q.size() != 0), 128'(1));
            if (model_q.size() != 0) begin
               exp_f = model_q.pop_front();
               chk("launch_frame", 128'({quantaDiv, propQuanta, seg1Quanta, datalen, format,
                                         frameType, id, xmitdata}), 128'(exp_f));
            end
            in_flight = 1'b1;
            @(negedge PCLK);
            chk("strobe_width", 128'(startXmit), 128'(0));
            if (xmode == 0) begin
               repeat (xd - 1) @(negedge PCLK);
               xc_busy = 1'b1;
               repeat (xl) @(negedge PCLK);
               xc_busy = 1'b0;
               @(posedge PCLK); #1;
               in_flight = 1'b0; done_exp = 1'b1;
            end else if (xmode == 1) begin
               repeat (BUSY_TIMEOUT - 1) @(posedge PCLK);
               #1;
               in_flight = 1'b0; err_exp = 1'b1;
            end
            if (xmode != 2 && model_q.size() != 0 && !hold_busy) begin
               repeat (2) @(posedge PCLK);
               #1;
               chk("next_launch", 128'(startXmit), 128'(1));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r; logic e; int l0;
      repeat (3) @(posedge PCLK);
      #1 PRESET = 1'b0;

      // reset state
      chk("rst_strobe", 128'(startXmit), 128'(0));
      chk("rst_irq", 128'(irq), 128'(0));
      chk("rst_head", 128'({id, xmitdata}), 128'(0));
      chk_status("rst_status");
      reg_rd("rst_dhi", 8'h00, 32'h0);
      apb(1'b1, 8'h20, 32'h1, r, e);
      chk("unmapped_wr_err", 128'(e), 128'(1));

      // single frame, fixed contents, launch latency
      xmode = 0; xd = 2; xl = 5;
      stage(32'hDEADBEEF, 32'h01234567, 32'h0A1234E0, 32'h12345678);
      reg_rd("cmd_rb", 8'h08, 32'h0A1234E0);
      reg_rd("id_rb", 8'h0C, 32'h12345678 & ~32'h7);
      push();
      chk("lat_edge0", 128'(startXmit), 128'(0));
      @(posedge PCLK); #1;
      chk("lat_edge1", 128'(startXmit), 128'(0));
      @(posedge PCLK); #1;
      chk("lat_edge2", 128'(startXmit), 128'(1));
      chk("t1_id", 128'(id), 128'(29'h2468ACF));
      chk("t1_dlen", 128'(datalen), 128'(4));
      chk("t1_data", 128'(xmitdata), 128'(64'hDEADBEEF_01234567));
      chk("t1_qdiv", 128'({quantaDiv, format, frameType}), 128'({8'h0A, 1'b1, 2'b11}));
      reg_rd("stage_kept", 8'h00, 32'hDEADBEEF);
      wait_drain(200);
      chk_irq("t1");

      // three queued frames with random busy pulses, done interrupt
      reg_wr(8'h14, 32'hFFFF_FFF9); ien_exp = 3'b001;
      reg_rd("ien_rb", 8'h14, 32'h1);
      w1c(3'b111);
      xd = $urandom_range(1, 4); xl = $urandom_range(5, 12);
      hold_busy = 1'b1;
      repeat (3) push_rand();
      chk_status("t2_status3");
      hold_busy = 1'b0;
      l0 = launches;
      wait_drain(400);
      chk("t2_launches", 128'(launches - l0), 128'(3));
      chk_irq("t2_done");
      w1c(3'b001);
      chk("t2_irq_clr", 128'(irq), 128'(0));

      // overflow with transmitter held busy, then drain in order
      hold_busy = 1'b1;
      repeat (DEPTH + 1) push_rand();
      chk_status("t3_full");
      chk_irq("t3_ovf");
      hold_busy = 1'b0;
      l0 = launches;
      wait_drain(600);
      chk("t3_launches", 128'(launches - l0), 128'(DEPTH));
      w1c(3'b111);

      // busy never rises: launch errors, each entry popped
      xmode = 1;
      hold_busy = 1'b1;
      repeat (2) push_rand();
      hold_busy = 1'b0;
      l0 = launches;
      wait_drain(200);
      chk("t4_launches", 128'(launches - l0), 128'(2));
      chk_status("t4_status");
      reg_wr(8'h14, 32'h4); ien_exp = 3'b100;
      chk_irq("t4_err");
      w1c(3'b111);
      xmode = 0;

      // flush while a frame is in flight
      xd = 2; xl = 80;
      repeat (3) push_rand();
      chk_status("t5_cnt3");
      apb(1'b1, 8'h10, 32'h2, r, e);
      chk("flush_err", 128'(e), 128'(0));
      model_q.delete();
      chk_status("t5_cnt1");
      wait_drain(300);
      chk_status("t5_cnt0");
      l0 = launches;
      repeat (10) @(posedge PCLK);
      #1 chk("t5_no_launch", 128'(launches), 128'(l0));

      // reset in the middle of a transmission
      xmode = 2;
      push_rand();
      for (int k = 0; k < 20 && !in_flight; k++) @(posedge PCLK);
      chk("t6_launched", 128'(in_flight), 128'(1));
      hold_busy = 1'b1;
      repeat (3) @(posedge PCLK);
      #1 PRESET = 1'b1;
      @(posedge PCLK);
      #1 PRESET = 1'b0;
      hold_busy = 1'b0;
      model_q.delete(); in_flight = 1'b0;
      done_exp = 1'b0; ovf_exp = 1'b0; err_exp = 1'b0; ien_exp = '0;
      chk("t6_strobe", 128'(startXmit), 128'(0));
      chk("t6_head", 128'({quantaDiv, id, xmitdata}), 128'(0));
      chk_status("t6_status");
      apb(1'b0, 8'h1C, 32'h0, r, e);
      chk("t6_unmapped_data", 128'(r), 128'(0));
      chk("t6_unmapped_err", 128'(e), 128'(1));
      reg_rd("t6_dhi", 8'h00, 32'h0);
      chk_irq("t6");
      l0 = launches;
      repeat (8) @(posedge PCLK);
      #1 chk("t6_no_launch", 128'(launches), 128'(l0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
